// File: rtl/pb_task_monitor_if.sv
// Purpose: bundles the builder-side observation signals and the completion record stream of pb_task_monitor.
// Latency: none, wiring only.
// Backpressure: cmpl_ready_i from the consumer side holds the head record.
// Ports (signals): start_i/busy_i/irq_i per channel; addr_in_i/byte_cnt_i/pkt_type_i per-channel config;
//   err_clr_i sticky-error clear; cmpl_* completion record stream; active_o/err_o per-channel status.
//   master = environment/consumer side, slave = monitor side.
interface pb_task_monitor_if #(
  parameter int NUM_CH = 2,
  parameter int ADDR_W = 32,
  parameter int CNT_W  = 16
);
  localparam int CH_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

  logic [NUM_CH-1:0]        start_i;
  logic [NUM_CH-1:0]        busy_i;
  logic [NUM_CH-1:0]        irq_i;
  logic [NUM_CH*ADDR_W-1:0] addr_in_i;
  logic [NUM_CH*4-1:0]      byte_cnt_i;
  logic [NUM_CH*4-1:0]      pkt_type_i;
  logic                     err_clr_i;
  logic                     cmpl_ready_i;

  logic                     cmpl_valid_o;
  logic [CH_W-1:0]          cmpl_ch_o;
  logic [ADDR_W-1:0]        cmpl_addr_o;
  logic [3:0]               cmpl_byte_cnt_o;
  logic [3:0]               cmpl_pkt_type_o;
  logic [CNT_W-1:0]         cmpl_cycles_o;
  logic [NUM_CH-1:0]        active_o;
  logic [NUM_CH*3-1:0]      err_o;

  modport master (
    output start_i, busy_i, irq_i, addr_in_i, byte_cnt_i, pkt_type_i, err_clr_i, cmpl_ready_i,
    input  cmpl_valid_o, cmpl_ch_o, cmpl_addr_o, cmpl_byte_cnt_o, cmpl_pkt_type_o, cmpl_cycles_o,
           active_o, err_o
  );

  modport slave (
    input  start_i, busy_i, irq_i, addr_in_i, byte_cnt_i, pkt_type_i, err_clr_i, cmpl_ready_i,
    output cmpl_valid_o, cmpl_ch_o, cmpl_addr_o, cmpl_byte_cnt_o, cmpl_pkt_type_o, cmpl_cycles_o,
           active_o, err_o
  );
endinterface

// File: rtl/pb_task_monitor.sv
// Purpose: tracks start/busy/irq task lifecycles on NUM_CH builder channels, times them, flags protocol errors.
// Latency: record visible 1 cycle after the irq edge, plus 1 cycle per lower-index channel also pending.
// Backpressure: cmpl_ready_i low fills the FWFT FIFO; once full, channels wait in DONE with frozen counters.
// Ports: clk, reset (async active-low), bus (pb_task_monitor_if.slave): per-channel inputs and config,
//   err_clr_i, completion record stream cmpl_*, active_o and sticky err_o {orphan irq, timeout, start-while-active}.
module pb_task_monitor #(
  parameter int NUM_CH     = 2,
  parameter int ADDR_W     = 32,
  parameter int CNT_W      = 16,
  parameter int MAX_CYC    = 1024,
  parameter int FIFO_DEPTH = 4
) (
  input logic              clk,
  input logic              reset,
  pb_task_monitor_if.slave bus
);
  localparam int CH_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
  localparam int AW   = $clog2(FIFO_DEPTH);

  typedef enum logic [2:0] {IDLE, ARMED, BUSY, WAIT_IRQ, DONE} state_t;

  typedef struct packed {
    logic [CH_W-1:0]   ch;
    logic [ADDR_W-1:0] addr;
    logic [3:0]        byte_cnt;
    logic [3:0]        pkt_type;
    logic [CNT_W-1:0]  cycles;
  } rec_t;

  state_t            st_q    [NUM_CH];
  state_t            st_d    [NUM_CH];
  logic [CNT_W-1:0]  cnt_q   [NUM_CH];
  logic [CNT_W-1:0]  cnt_d   [NUM_CH];
  logic [CNT_W-1:0]  cnt_inc [NUM_CH];
  logic [ADDR_W-1:0] addr_q  [NUM_CH];
  logic [ADDR_W-1:0] addr_d  [NUM_CH];
  logic [3:0]        bc_q    [NUM_CH];
  logic [3:0]        bc_d    [NUM_CH];
  logic [3:0]        pt_q    [NUM_CH];
  logic [3:0]        pt_d    [NUM_CH];
  logic [CNT_W-1:0]  cyc_q   [NUM_CH];
  logic [CNT_W-1:0]  cyc_d   [NUM_CH];
  logic [2:0]        err_q   [NUM_CH];
  logic [2:0]        err_d   [NUM_CH];
  logic [2:0]        ev      [NUM_CH];

  logic [NUM_CH-1:0]   grant;
  logic [NUM_CH-1:0]   active;
  logic [NUM_CH*3-1:0] err_vec;
  logic                push, pop, can_push, head_vld;
  rec_t                push_rec, head;

  rec_t              mem [FIFO_DEPTH];
  logic [AW-1:0]     wr_ptr_q, rd_ptr_q;
  logic [AW:0]       count_q;

  assign head_vld = (count_q != '0);
  assign pop      = head_vld & bus.cmpl_ready_i;
  // A pop on the same edge frees the slot, so a full FIFO still takes a push.
  assign can_push = (count_q != (AW+1)'(FIFO_DEPTH)) | pop;
  assign push     = |grant;

  // Fixed priority: scanning downward leaves the lowest pending index as the winner.
  always_comb begin
    grant    = '0;
    push_rec = '0;
    if (can_push) begin
      for (int c = NUM_CH-1; c >= 0; c--) begin
        if (st_q[c] == DONE) begin
          grant             = '0;
          grant[c]          = 1'b1;
          push_rec.ch       = CH_W'(c);
          push_rec.addr     = addr_q[c];
          push_rec.byte_cnt = bc_q[c];
          push_rec.pkt_type = pt_q[c];
          push_rec.cycles   = cyc_q[c];
        end
      end
    end
  end

  always_comb begin
    for (int c = 0; c < NUM_CH; c++) begin
      st_d[c]    = st_q[c];
      cnt_d[c]   = cnt_q[c];
      cnt_inc[c] = cnt_q[c] + CNT_W'(1);
      addr_d[c]  = addr_q[c];
      bc_d[c]    = bc_q[c];
      pt_d[c]    = pt_q[c];
      cyc_d[c]   = cyc_q[c];
      ev[c]      = 3'b000;
      unique case (st_q[c])
        IDLE: begin
          if (bus.start_i[c]) begin
            addr_d[c] = bus.addr_in_i[c*ADDR_W +: ADDR_W];
            bc_d[c]   = bus.byte_cnt_i[c*4 +: 4];
            pt_d[c]   = bus.pkt_type_i[c*4 +: 4];
            cnt_d[c]  = '0;
            st_d[c]   = ARMED;
          end
          if (bus.irq_i[c]) ev[c][2] = 1'b1;
        end
        ARMED, BUSY, WAIT_IRQ: begin
          if (bus.start_i[c]) ev[c][0] = 1'b1;
          cnt_d[c] = cnt_inc[c];
          // irq has priority over both the timeout and the busy transitions.
          if (bus.irq_i[c]) begin
            cyc_d[c] = cnt_inc[c];
            st_d[c]  = DONE;
          end else if (cnt_inc[c] == CNT_W'(MAX_CYC)) begin
            ev[c][1] = 1'b1;
            st_d[c]  = IDLE;
          end else if (st_q[c] == ARMED && bus.busy_i[c]) begin
            st_d[c] = BUSY;
          end else if (st_q[c] == BUSY && !bus.busy_i[c]) begin
            st_d[c] = WAIT_IRQ;
          end
        end
        DONE: begin
          // Counter stays frozen here so FIFO stalls never look like a timeout.
          if (bus.start_i[c]) ev[c][0] = 1'b1;
          if (grant[c]) st_d[c] = IDLE;
        end
        default: st_d[c] = IDLE;
      endcase
      // Clear first, then OR in events: a same-cycle event survives the clear.
      err_d[c] = (bus.err_clr_i ? 3'b000 : err_q[c]) | ev[c];
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int c = 0; c < NUM_CH; c++) begin
        st_q[c]   <= IDLE;
        cnt_q[c]  <= '0;
        addr_q[c] <= '0;
        bc_q[c]   <= '0;
        pt_q[c]   <= '0;
        cyc_q[c]  <= '0;
        err_q[c]  <= '0;
      end
    end else begin
      for (int c = 0; c < NUM_CH; c++) begin
        st_q[c]   <= st_d[c];
        cnt_q[c]  <= cnt_d[c];
        addr_q[c] <= addr_d[c];
        bc_q[c]   <= bc_d[c];
        pt_q[c]   <= pt_d[c];
        cyc_q[c]  <= cyc_d[c];
        err_q[c]  <= err_d[c];
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
      case ({push, pop})
        2'b10:   count_q <= count_q + (AW+1)'(1);
        2'b01:   count_q <= count_q - (AW+1)'(1);
        default: count_q <= count_q;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr_q] <= push_rec;
  end

  // Record fields read as zero whenever nothing is queued, including right after reset.
  assign head = head_vld ? mem[rd_ptr_q] : '0;

  always_comb begin
    for (int c = 0; c < NUM_CH; c++) begin
      active[c]          = (st_q[c] != IDLE);
      err_vec[c*3 +: 3]  = err_q[c];
    end
  end

  assign bus.cmpl_valid_o    = head_vld;
  assign bus.cmpl_ch_o       = head.ch;
  assign bus.cmpl_addr_o     = head.addr;
  assign bus.cmpl_byte_cnt_o = head.byte_cnt;
  assign bus.cmpl_pkt_type_o = head.pkt_type;
  assign bus.cmpl_cycles_o   = head.cycles;
  assign bus.active_o        = active;
  assign bus.err_o           = err_vec;
endmodule

// File: tb/tb_pb_task_monitor.sv
`timescale 1ns/1ps
module tb_pb_task_monitor;
  localparam int NUM_CH = 2, ADDR_W = 32, CNT_W = 16, MAX_CYC = 1024, FIFO_DEPTH = 4;
  localparam int VW = 1 + 1 + ADDR_W + 4 + 4 + CNT_W + NUM_CH + NUM_CH*3;

  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  pb_task_monitor_if #(.NUM_CH(NUM_CH), .ADDR_W(ADDR_W), .CNT_W(CNT_W)) bus ();

  pb_task_monitor #(
    .NUM_CH(NUM_CH), .ADDR_W(ADDR_W), .CNT_W(CNT_W), .MAX_CYC(MAX_CYC), .FIFO_DEPTH(FIFO_DEPTH)
  ) dut (
    .clk(clk),
    .reset(reset),
    .bus(bus)
  );

  int checks = 0;
  int passes = 0;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  // Reference model: a channel is idle, running (timed since its start edge) or holding a finished record.
  typedef struct { int ch; logic [31:0] addr; logic [3:0] bc; logic [3:0] pt; int cyc; } rec_t;
  rec_t       exp_q[$];
  int         m_phase [NUM_CH];
  int         m_t0    [NUM_CH];
  rec_t       m_rec   [NUM_CH];
  logic [2:0] m_err   [NUM_CH];
  int         ecnt = 0;

  function automatic void model_clear();
    exp_q.delete();
    for (int c = 0; c < NUM_CH; c++) begin
      m_phase[c] = 0;
      m_t0[c]    = 0;
      m_err[c]   = 3'b000;
    end
  endfunction

  function automatic void model_step();
    int g = -1;
    bit pop;
    logic [2:0] e;
    pop = (exp_q.size() > 0) && bus.cmpl_ready_i;
    if (exp_q.size() < FIFO_DEPTH || pop)
      for (int c = NUM_CH-1; c >= 0; c--) if (m_phase[c] == 2) g = c;
    for (int c = 0; c < NUM_CH; c++) begin
      e = 3'b000;
      if (bus.start_i[c] && m_phase[c] != 0) e[0] = 1'b1;
      if (m_phase[c] == 0) begin
        if (bus.irq_i[c]) e[2] = 1'b1;
        if (bus.start_i[c]) begin
          m_phase[c]    = 1;
          m_t0[c]       = ecnt;
          m_rec[c].ch   = c;
          m_rec[c].addr = bus.addr_in_i[c*ADDR_W +: ADDR_W];
          m_rec[c].bc   = bus.byte_cnt_i[c*4 +: 4];
          m_rec[c].pt   = bus.pkt_type_i[c*4 +: 4];
        end
      end else if (m_phase[c] == 1) begin
        if (bus.irq_i[c]) begin
          m_rec[c].cyc = ecnt - m_t0[c];
          m_phase[c]   = 2;
        end else if (ecnt - m_t0[c] == MAX_CYC) begin
          e[1]       = 1'b1;
          m_phase[c] = 0;
        end
      end else if (g == c) begin
        m_phase[c] = 0;
      end
      m_err[c] = (bus.err_clr_i ? 3'b000 : m_err[c]) | e;
    end
    if (pop) void'(exp_q.pop_front());
    if (g >= 0) exp_q.push_back(m_rec[g]);
  endfunction

  function automatic logic [VW-1:0] exp_vec();
    rec_t h;
    logic [NUM_CH-1:0] act;
    logic [NUM_CH*3-1:0] e;
    logic v;
    h = '{0, 32'h0, 4'h0, 4'h0, 0};
    v = exp_q.size() > 0;
    if (v) h = exp_q[0];
    for (int c = 0; c < NUM_CH; c++) begin
      act[c]       = (m_phase[c] != 0);
      e[c*3 +: 3]  = m_err[c];
    end
    return {v, 1'(h.ch), h.addr, h.bc, h.pt, 16'(h.cyc), act, e};
  endfunction

  function automatic logic [VW-1:0] dut_vec();
    return {bus.cmpl_valid_o, bus.cmpl_ch_o, bus.cmpl_addr_o, bus.cmpl_byte_cnt_o,
            bus.cmpl_pkt_type_o, bus.cmpl_cycles_o, bus.active_o, bus.err_o};
  endfunction

  initial begin
    model_clear();
    forever begin
      @(posedge clk);
      ecnt++;
      if (reset) model_step();
      else model_clear();
      #2;
      if (!reset) model_clear();
      check("model", 128'(dut_vec()), 128'(exp_vec()));
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_cfg(input int ch, input logic [31:0] a, input logic [3:0] b, input logic [3:0] p);
    bus.addr_in_i[ch*ADDR_W +: ADDR_W] = a;
    bus.byte_cnt_i[ch*4 +: 4]          = b;
    bus.pkt_type_i[ch*4 +: 4]          = p;
  endtask

  // Start sampled at edge k, busy high for edges k+1..k+bl, irq sampled at edge k+bl+gap+1.
  task automatic run_task(input int ch, input logic [31:0] a, input logic [3:0] b, input logic [3:0] p,
                          input int bl, input int gap);
    set_cfg(ch, a, b, p);
    bus.start_i[ch] = 1'b1;
    tick();
    bus.start_i[ch] = 1'b0;
    check("active_after_start", 128'(bus.active_o[ch]), 128'(1));
    if (bl > 0) begin
      bus.busy_i[ch] = 1'b1;
      repeat (bl) tick();
      bus.busy_i[ch] = 1'b0;
    end
    repeat (gap) tick();
    bus.irq_i[ch] = 1'b1;
    tick();
    bus.irq_i[ch] = 1'b0;
  endtask

  task automatic check_rec(input string tag, input int ch, input logic [31:0] a, input logic [3:0] b,
                           input logic [3:0] p, input int cyc);
    check({tag, "_valid"}, 128'(bus.cmpl_valid_o), 128'(1));
    check({tag, "_ch"},    128'(bus.cmpl_ch_o), 128'(ch));
    check({tag, "_addr"},  128'(bus.cmpl_addr_o), 128'(a));
    check({tag, "_bc"},    128'(bus.cmpl_byte_cnt_o), 128'(b));
    check({tag, "_pt"},    128'(bus.cmpl_pkt_type_o), 128'(p));
    check({tag, "_cyc"},   128'(bus.cmpl_cycles_o), 128'(cyc));
  endtask

  typedef struct { int ch; logic [31:0] addr; logic [3:0] bc; logic [3:0] pt; int bl; int gap; int cyc; } vec_t;
  vec_t vecs [5];

  initial begin
    vecs[0] = '{0, 32'h0000_0100, 4'd5,  4'd3,  10, 2, 13};
    vecs[1] = '{1, 32'hABCD_0000, 4'd15, 4'd0,  0,  0, 1};
    vecs[2] = '{0, 32'hFFFF_FFFF, 4'd0,  4'd15, 3,  0, 4};
    vecs[3] = '{1, 32'h1234_5678, 4'd9,  4'd6,  1,  5, 7};
    vecs[4] = '{1, 32'h0000_0000, 4'd1,  4'd1,  20, 3, 24};

    bus.start_i = '0; bus.busy_i = '0; bus.irq_i = '0;
    bus.addr_in_i = '0; bus.byte_cnt_i = '0; bus.pkt_type_i = '0;
    bus.err_clr_i = 1'b0; bus.cmpl_ready_i = 1'b1;

    tick(); tick();
    check("reset_valid",  128'(bus.cmpl_valid_o), 128'(0));
    check("reset_active", 128'(bus.active_o), 128'(0));
    check("reset_err",    128'(bus.err_o), 128'(0));
    check("reset_fields", 128'({bus.cmpl_ch_o, bus.cmpl_addr_o, bus.cmpl_byte_cnt_o,
                                bus.cmpl_pkt_type_o, bus.cmpl_cycles_o}), 128'(0));
    reset = 1'b1;
    tick();

    // Single-task vectors: record appears exactly one edge after the irq edge.
    for (int i = 0; i < 5; i++) begin
      run_task(vecs[i].ch, vecs[i].addr, vecs[i].bc, vecs[i].pt, vecs[i].bl, vecs[i].gap);
      check("no_rec_on_irq_edge", 128'(bus.cmpl_valid_o), 128'(0));
      tick();
      check_rec("vec", vecs[i].ch, vecs[i].addr, vecs[i].bc, vecs[i].pt, vecs[i].cyc);
      check("vec_err", 128'(bus.err_o), 128'(0));
      tick();
      check("vec_drained", 128'(bus.cmpl_valid_o), 128'(0));
      tick();
    end

    // Simultaneous irq on both channels: ch0 first, ch1 one cycle later.
    set_cfg(0, 32'hA0, 4'd2, 4'd1);
    set_cfg(1, 32'hA1, 4'd3, 4'd2);
    bus.start_i = 2'b11;
    tick();
    bus.start_i = 2'b00;
    repeat (4) tick();
    bus.irq_i = 2'b11;
    tick();
    bus.irq_i = 2'b00;
    check("simul_m", 128'(bus.cmpl_valid_o), 128'(0));
    tick();
    check_rec("simul_ch0", 0, 32'hA0, 4'd2, 4'd1, 5);
    tick();
    check_rec("simul_ch1", 1, 32'hA1, 4'd3, 4'd2, 5);
    tick();
    check("simul_empty", 128'(bus.cmpl_valid_o), 128'(0));

    // Backpressure: six completions into a 4-deep FIFO, then drain in order.
    bus.cmpl_ready_i = 1'b0;
    for (int i = 0; i < 6; i++) begin
      run_task(i % 2, 32'h200 + i, 4'(i), 4'(i + 8), 0, i);
      tick();
    end
    tick();
    check("bp_active", 128'(bus.active_o), 128'(2'b11));
    check("bp_head",   128'(bus.cmpl_addr_o), 128'(32'h200));
    bus.cmpl_ready_i = 1'b1;
    for (int i = 0; i < 6; i++) begin
      check_rec("drain", i % 2, 32'h200 + i, 4'(i), 4'(i + 8), i + 1);
      tick();
    end
    check("drain_empty",  128'(bus.cmpl_valid_o), 128'(0));
    check("drain_active", 128'(bus.active_o), 128'(0));

    // Timeout on ch1 at elapsed edge 1024.
    set_cfg(1, 32'hDEAD, 4'd4, 4'd4);
    bus.start_i[1] = 1'b1;
    tick();
    bus.start_i[1] = 1'b0;
    bus.busy_i[1] = 1'b1;
    repeat (5) tick();
    bus.busy_i[1] = 1'b0;
    repeat (MAX_CYC - 6) tick();
    check("to_before_err",    128'(bus.err_o), 128'(0));
    check("to_before_active", 128'(bus.active_o), 128'(2'b10));
    tick();
    check("to_err",    128'(bus.err_o), 128'(6'b010_000));
    check("to_active", 128'(bus.active_o), 128'(0));
    tick();
    check("to_no_rec", 128'(bus.cmpl_valid_o), 128'(0));
    bus.err_clr_i = 1'b1;
    tick();
    bus.err_clr_i = 1'b0;
    check("to_clr", 128'(bus.err_o), 128'(0));

    // irq on exactly the timeout edge wins.
    set_cfg(1, 32'hBEEF, 4'd7, 4'd9);
    bus.start_i[1] = 1'b1;
    tick();
    bus.start_i[1] = 1'b0;
    repeat (MAX_CYC - 1) tick();
    bus.irq_i[1] = 1'b1;
    tick();
    bus.irq_i[1] = 1'b0;
    check("edge_irq_err", 128'(bus.err_o), 128'(0));
    tick();
    check_rec("edge_irq", 1, 32'hBEEF, 4'd7, 4'd9, MAX_CYC);
    tick(); tick();

    // Restart while busy keeps the first config; orphan irq; clear.
    set_cfg(0, 32'h500, 4'd1, 4'd2);
    bus.start_i[0] = 1'b1;
    tick();
    bus.start_i[0] = 1'b0;
    bus.busy_i[0] = 1'b1;
    tick(); tick();
    set_cfg(0, 32'h600, 4'd3, 4'd4);
    bus.start_i[0] = 1'b1;
    tick();
    bus.start_i[0] = 1'b0;
    check("restart_err", 128'(bus.err_o), 128'(6'b000_001));
    bus.busy_i[0] = 1'b0;
    tick();
    bus.irq_i[0] = 1'b1;
    tick();
    bus.irq_i[0] = 1'b0;
    tick();
    check_rec("restart", 0, 32'h500, 4'd1, 4'd2, 5);
    bus.irq_i[1] = 1'b1;
    tick();
    bus.irq_i[1] = 1'b0;
    check("orphan_err", 128'(bus.err_o), 128'(6'b100_001));
    bus.err_clr_i = 1'b1;
    tick();
    bus.err_clr_i = 1'b0;
    check("clr_err", 128'(bus.err_o), 128'(0));

    // Asynchronous reset mid-task with two queued records.
    bus.cmpl_ready_i = 1'b0;
    run_task(0, 32'h300, 4'd1, 4'd1, 1, 1); tick();
    run_task(1, 32'h301, 4'd2, 4'd2, 0, 2); tick();
    set_cfg(0, 32'h302, 4'd3, 4'd3);
    bus.start_i[0] = 1'b1;
    bus.irq_i[1]   = 1'b1;
    tick();
    bus.start_i = '0;
    bus.irq_i   = '0;
    check("pre_rst_valid", 128'(bus.cmpl_valid_o), 128'(1));
    check("pre_rst_err",   128'(bus.err_o), 128'(6'b100_000));
    reset = 1'b0;
    #1;
    check("rst_valid",  128'(bus.cmpl_valid_o), 128'(0));
    check("rst_active", 128'(bus.active_o), 128'(0));
    check("rst_err",    128'(bus.err_o), 128'(0));
    tick();
    reset = 1'b1;
    bus.cmpl_ready_i = 1'b1;
    tick();
    run_task(0, 32'h700, 4'd6, 4'd5, 2, 1);
    tick();
    check_rec("post_rst", 0, 32'h700, 4'd6, 4'd5, 4);
    tick(); tick();

    // Random traffic checked every cycle against the reference model.
    for (int n = 0; n < 4000; n++) begin
      for (int c = 0; c < NUM_CH; c++) begin
        bus.start_i[c] = ($urandom_range(0, 15) == 0);
        bus.busy_i[c]  = $urandom_range(0, 1) == 1;
        bus.irq_i[c]   = (m_phase[c] == 1) ? ($urandom_range(0, 9) == 0) : ($urandom_range(0, 63) == 0);
        set_cfg(c, $urandom, 4'($urandom), 4'($urandom));
      end
      bus.err_clr_i = ($urandom_range(0, 39) == 0);
      if ($urandom_range(0, 11) == 0) bus.cmpl_ready_i = ~bus.cmpl_ready_i;
      tick();
    end
    bus.start_i = '0; bus.irq_i = '0; bus.busy_i = '0; bus.err_clr_i = 1'b0;
    bus.cmpl_ready_i = 1'b1;
    repeat (10) tick();

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end
endmodule
